// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC and fetches one 32-bit word per fetch_enable
// assertion over a req/ack memory bus, flagging misaligned PCs and memory timeouts.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_enable,
  output logic        fetch_done,
  output logic [31:0] instruction,
  output logic        fetch_error,
  output logic [31:0] pc,
  input  logic        pc_load,
  input  logic [31:0] pc_load_value,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pc_n, addr_n, instr_n;
  logic          req_n, done_n, err_n;

  assign fsm_state = state;

  // Handshake: imem_req rises with imem_addr and holds both stable until the edge
  // that samples imem_ack=1 (or the timeout edge); ack is ignored while req is low.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    addr_n  = imem_addr;
    req_n   = imem_req;
    done_n  = 1'b0;
    err_n   = fetch_error;
    instr_n = instruction;
    case (state)
      IDLE: begin
        if (fetch_enable) begin
          if (pc[1:0] != 2'b00) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            instr_n = NOP_INSTR;
            state_n = RELEASE;
          end else begin
            req_n   = 1'b1;
            addr_n  = pc;
            cnt_n   = '0;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack arriving on the timeout edge still completes normally.
        if (imem_ack) begin
          instr_n = imem_rdata;
          done_n  = 1'b1;
          err_n   = 1'b0;
          req_n   = 1'b0;
          pc_n    = pc + 32'd4;
          state_n = RELEASE;
        end else if (cnt == CNT_LAST) begin
          instr_n = NOP_INSTR;
          done_n  = 1'b1;
          err_n   = 1'b1;
          req_n   = 1'b0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!fetch_enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Redirect wins over the post-fetch increment; imem_addr is left alone.
    if (pc_load) pc_n = pc_load_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      imem_addr   <= 32'h0;
      imem_req    <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_error <= 1'b0;
      instruction <= NOP_INSTR;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      imem_req    <= req_n;
      fetch_done  <= done_n;
      fetch_error <= err_n;
      instruction <= instr_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: the driver also plays the
// instruction memory, a PC-level model predicts each fetch result and request address.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          TMO      = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        fetch_done;
  logic [31:0] instruction;
  logic        fetch_error;
  logic [31:0] pc;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_value = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Expected result per fetch: {fetch_error, instruction, pc after completion}
  logic [64:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] model_pc;

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable),
    .fetch_done(fetch_done), .instruction(instruction), .fetch_error(fetch_error),
    .pc(pc), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a result.
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    logic [64:0] e;
    if (imem_req && !prev_req) begin
      if (addr_q.size() == 0) check("unexpected_req", 64'(imem_addr), 64'hdead);
      else check("imem_addr", 64'(imem_addr), 64'(addr_q.pop_front()));
    end
    if (fetch_done) begin
      if (prev_done) check("done_pulse_width", 64'd2, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(instruction), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("fetch_error", 64'(fetch_error), 64'(e[64]));
        check("instruction", 64'(instruction), 64'(e[63:32]));
        check("pc_after", 64'(pc), 64'(e[31:0]));
      end
      done_seen++;
    end
    prev_req  = imem_req;
    prev_done = fetch_done;
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_rise_timeout", 64'(imem_req), 64'd1);
  endtask

  // One fetch: optional redirect in IDLE, then memory acks after w idle edges
  // (w >= TMO means never), optional redirect on the ack edge, enable held for hold cycles.
  task automatic do_fetch(input bit do_load, input logic [31:0] load_val, input int w,
                          input logic [31:0] rdata, input bit ack_load,
                          input logic [31:0] ack_val, input bit drop_early, input int hold);
    int target, n, hi;
    target = done_seen + 1;
    @(negedge clk);
    if (do_load) begin
      pc_load = 1'b1;
      pc_load_value = load_val;
      @(negedge clk);
      pc_load = 1'b0;
      model_pc = load_val;
    end
    if (model_pc[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, NOP, model_pc});
      fetch_enable = 1'b1;
    end else begin
      addr_q.push_back(model_pc);
      fetch_enable = 1'b1;
      @(negedge clk);
      wait_req();
      if (drop_early) fetch_enable = 1'b0;
      if (w >= TMO) begin
        exp_q.push_back({1'b1, NOP, model_pc});
        hi = 1;
        n = 0;
        while (n < 40) begin
          @(negedge clk);
          if (!imem_req) break;
          hi++;
          n++;
        end
        check("timeout_req_cycles", 64'(hi), 64'(TMO));
      end else begin
        repeat (w) @(negedge clk);
        if (ack_load) begin
          pc_load = 1'b1;
          pc_load_value = ack_val;
          model_pc = ack_val;
        end else begin
          model_pc = model_pc + 32'd4;
        end
        exp_q.push_back({1'b0, rdata, model_pc});
        imem_ack = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack = 1'b0;
        pc_load = 1'b0;
      end
    end
    n = 0;
    while (done_seen < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(done_seen >= target), 64'd1);
    if (fetch_enable) repeat (hold) @(negedge clk);
    fetch_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int w;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc), 64'(RESET_PC));
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_err", 64'(fetch_error), 64'd0);
    check("rst_instr", 64'(instruction), 64'(NOP));
    reset_n = 1'b1;
    model_pc = RESET_PC;

    // Basic fetch, then enable held 10 cycles without a second request
    do_fetch(0, 0, 1, 32'h0050_0093, 0, 0, 0, 10);
    do_fetch(0, 0, 0, 32'h1234_5678, 0, 0, 0, 0);
    // Timeout, then ack on the last possible edge
    do_fetch(0, 0, TMO + 2, 32'h0, 0, 0, 0, 0);
    do_fetch(0, 0, TMO - 1, 32'hcafe_f00d, 0, 0, 1, 0);
    // Redirects: in IDLE, then on the ack edge
    do_fetch(1, 32'h100, 2, 32'h0000_0fff, 0, 0, 0, 2);
    do_fetch(0, 0, 0, 32'h0a0b_0c0d, 1, 32'h200, 0, 0);
    // Misaligned PC: no request, error pulse, pc held
    do_fetch(1, 32'h102, 0, 32'h0, 0, 0, 0, 3);
    // Wrap from the top of the address space
    do_fetch(1, 32'hFFFF_FFFC, 3, 32'h7777_7777, 0, 0, 0, 0);

    // Asynchronous reset mid-fetch; late ack must be ignored
    @(negedge clk);
    addr_q.push_back(model_pc);
    fetch_enable = 1'b1;
    @(negedge clk);
    wait_req();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_req", 64'(imem_req), 64'd0);
    check("async_rst_pc", 64'(pc), 64'(RESET_PC));
    fetch_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_pc = RESET_PC;
    imem_ack = 1'b1;
    imem_rdata = 32'hbad0_bad0;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_pc", 64'(pc), 64'(RESET_PC));

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit do_load;
      int r;
      do_load = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      v = $urandom();
      if (r == 0) v = (v & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (r == 1) v = 32'hFFFF_FFFC;
      else v = v & 32'h0000_FFFC;
      if ($urandom_range(0, 4) == 0) w = $urandom_range(TMO - 2, TMO + 2);
      else w = $urandom_range(0, 4);
      do_fetch(do_load, v, w, $urandom(), ($urandom_range(0, 5) == 0),
               $urandom() & 32'h0000_FFFC, bit'($urandom_range(0, 1)),
               $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
